// File: rtl/traffic_ctrl.sv
// Intersection light sequencer driving an external down-counting timer.
// Optional pedestrian walk phase is enabled by defining WALK_REQUEST_EN.
module traffic_ctrl #(
   parameter int N        = 4,
   parameter int TICK_DIV = 4,
   parameter int T_MAIN_G = 10,
   parameter int T_SIDE_G = 6,
   parameter int T_YELLOW = 3,
   parameter int T_RED    = 1,
   parameter int T_WALK   = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sensor,
   input  logic         walk_btn,
   input  logic [N-1:0] timer_out,
   output logic         timer_load,
   output logic [N-1:0] timer_init,
   output logic         timer_en,
   output logic [2:0]   main_light,
   output logic [2:0]   side_light,
   output logic         walk_light
);

   typedef enum logic [2:0] {
      MAIN_G = 3'd0,
      MAIN_Y = 3'd1,
      RED_A  = 3'd2,
      SIDE_G = 3'd3,
      SIDE_Y = 3'd4,
      RED_B  = 3'd5,
      WALK   = 3'd6
   } state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;

   state_t        state;
   state_t        state_next;
   logic          load_pending;
   logic [PW-1:0] presc;
   logic          tick;
   logic          expire;
   logic          walk_req;

   assign timer_load = load_pending;
   assign tick       = (presc == PW'(TICK_DIV - 1));
   assign timer_en   = tick & ~load_pending;
   // The timer still shows the previous state's zero during the load cycle.
   assign expire     = (timer_out == '0) & ~load_pending;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= MAIN_G;
         load_pending <= 1'b1;
         presc        <= '0;
      end else begin
         state        <= state_next;
         load_pending <= (state_next != state);
         if (load_pending || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

`ifdef WALK_REQUEST_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         walk_req <= 1'b0;
      end else if ((state != WALK) && (state_next == WALK)) begin
         walk_req <= 1'b0;
      end else if (walk_btn && (state != WALK)) begin
         walk_req <= 1'b1;
      end
   end

   assign walk_light = (state == WALK);
`else
   logic unused_walk_btn;
   assign unused_walk_btn = walk_btn;
   assign walk_req        = 1'b0;
   assign walk_light      = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         MAIN_G: if (expire && (sensor || walk_req)) state_next = MAIN_Y;
         MAIN_Y: if (expire) state_next = RED_A;
         RED_A:  if (expire) state_next = SIDE_G;
         SIDE_G: if (expire) state_next = SIDE_Y;
         SIDE_Y: if (expire) state_next = RED_B;
         RED_B:  if (expire) state_next = walk_req ? WALK : MAIN_G;
         WALK:   if (expire) state_next = MAIN_G;
         default: state_next = MAIN_G;
      endcase
   end

   always_comb begin
      main_light = LIGHT_RED;
      side_light = LIGHT_RED;
      timer_init = N'(T_RED);
      case (state)
         MAIN_G: begin
            main_light = LIGHT_GREEN;
            timer_init = N'(T_MAIN_G);
         end
         MAIN_Y: begin
            main_light = LIGHT_YELLOW;
            timer_init = N'(T_YELLOW);
         end
         SIDE_G: begin
            side_light = LIGHT_GREEN;
            timer_init = N'(T_SIDE_G);
         end
         SIDE_Y: begin
            side_light = LIGHT_YELLOW;
            timer_init = N'(T_YELLOW);
         end
         WALK:   timer_init = N'(T_WALK);
         default: timer_init = N'(T_RED);
      endcase
   end

endmodule
